memory_port_arbiter: RTL and testbench

Shares one single-port unified instruction/data memory between the instruction fetch requester and the MEM-stage data requester.
- Arbitrates between the two requesters and sequences a fixed-latency memory access.
- Returns read data and a one-cycle ready pulse to the winner.
- Data access has priority; a starvation guard bounds fetch wait.

---
 rtl/memory_port_arbiter.sv | 148 ++++++++++++++
 tb/tb_memory_port_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : memory_port_arbiter
// Description : Shares one single-port memory between instruction fetch and
//               data access, with data priority and a fetch starvation guard.
// Revision    : 1.0 - initial release
// ============================================================================
module memory_port_arbiter #(
  parameter int MEMORY_LATENCY   = 2,
  parameter int STARVATION_LIMIT = 4,
  parameter int ADDRESS_WIDTH    = 32
) (
  input  logic                     system_clock,
  input  logic                     reset,
  input  logic                     fetch_request,
  input  logic [ADDRESS_WIDTH-1:0] fetch_address,
  output logic                     fetch_ready,
  output logic [31:0]              fetch_read_data,
  input  logic                     data_request,
  input  logic                     data_write,
  input  logic [ADDRESS_WIDTH-1:0] data_address,
  input  logic [31:0]              data_write_data,
  output logic                     data_ready,
  output logic [31:0]              data_read_data,
  output logic                     memory_enable,
  output logic                     memory_write,
  output logic [ADDRESS_WIDTH-1:0] memory_address,
  output logic [31:0]              memory_write_data,
  input  logic [31:0]              memory_read_data,
  output logic                     busy,
  output logic                     grant_owner
);

  localparam logic [1:0] c_state_idle   = 2'd0;
  localparam logic [1:0] c_state_access = 2'd1;
  localparam logic [1:0] c_state_done   = 2'd2;
  localparam logic [3:0] c_last_count   = 4'(MEMORY_LATENCY - 1);
  localparam logic [7:0] c_starve_limit = 8'(STARVATION_LIMIT);

  logic [1:0]               r_state;
  logic [1:0]               w_next_state;
  logic [3:0]               r_latency_count;
  logic [7:0]               r_starve_count;
  logic                     r_owner;
  logic [ADDRESS_WIDTH-1:0] r_address;
  logic                     r_write;
  logic [31:0]              r_write_data;
  logic [31:0]              r_fetch_read_data;
  logic [31:0]              r_data_read_data;
  logic                     w_any_request;
  logic                     w_grant_data;
  logic                     w_last_access;

  assign w_any_request = fetch_request | data_request;
  // Fetch overrides data only once it has been passed over STARVATION_LIMIT times.
  assign w_grant_data  = data_request & ~(fetch_request & (r_starve_count == c_starve_limit));
  assign w_last_access = (r_latency_count == c_last_count);

  always_ff @(posedge system_clock or negedge reset) begin
    if (!reset) begin
      r_state <= c_state_idle;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_state_idle:   if (w_any_request) w_next_state = c_state_access;
      c_state_access: if (w_last_access) w_next_state = c_state_done;
      c_state_done:   w_next_state = c_state_idle;
      default:        w_next_state = c_state_idle;
    endcase
  end

  always_comb begin
    memory_enable = 1'b0;
    memory_write  = 1'b0;
    fetch_ready   = 1'b0;
    data_ready    = 1'b0;
    busy          = (r_state != c_state_idle);
    case (r_state)
      c_state_access: begin
        memory_enable = 1'b1;
        memory_write  = r_write;
      end
      c_state_done: begin
        fetch_ready = ~r_owner;
        data_ready  = r_owner;
      end
      default: ;
    endcase
  end

  always_ff @(posedge system_clock or negedge reset) begin
    if (!reset) begin
      r_latency_count   <= 4'd0;
      r_starve_count    <= 8'd0;
      r_owner           <= 1'b0;
      r_address         <= '0;
      r_write           <= 1'b0;
      r_write_data      <= 32'd0;
      r_fetch_read_data <= 32'd0;
      r_data_read_data  <= 32'd0;
    end else begin
      case (r_state)
        c_state_idle: begin
          if (w_any_request) begin
            r_owner         <= w_grant_data;
            r_latency_count <= 4'd0;
            if (w_grant_data) begin
              r_address      <= data_address;
              r_write        <= data_write;
              r_write_data   <= data_write_data;
              r_starve_count <= fetch_request ? r_starve_count + 8'd1 : 8'd0;
            end else begin
              r_address      <= fetch_address;
              r_write        <= 1'b0;
              r_write_data   <= 32'd0;
              r_starve_count <= 8'd0;
            end
          end
        end
        c_state_access: begin
          if (w_last_access) begin
            r_latency_count <= 4'd0;
            if (!r_write) begin
              if (r_owner) r_data_read_data  <= memory_read_data;
              else         r_fetch_read_data <= memory_read_data;
            end
          end else begin
            r_latency_count <= r_latency_count + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign memory_address    = r_address;
  assign memory_write_data = r_write_data;
  assign fetch_read_data   = r_fetch_read_data;
  assign data_read_data    = r_data_read_data;
  assign grant_owner       = r_owner;

endmodule
`default_nettype wire

// File: tb/tb_memory_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_memory_port_arbiter
// Description : Self-checking bench: transaction-level timing model plus
//               directed scenarios and randomized requesters.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_memory_port_arbiter;
  localparam int LAT   = 2;
  localparam int LIMIT = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        fr, dr, dw;
  logic [31:0] fa, da, dwd;
  logic        fready, dready, men, mwr, busy, gown;
  logic [31:0] fdata, ddata, maddr, mwd, mrd;
  logic        ovr_en;
  logic [31:0] ovr_val;

  logic        fr1;
  logic [31:0] fa1;
  logic        zero1;
  logic [31:0] zero32;
  logic        fready1, dready1, men1, mwr1, busy1, gown1;
  logic [31:0] fdata1, ddata1, maddr1, mwd1, mrd1;

  function automatic logic [31:0] hash(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  assign mrd  = ovr_en ? ovr_val : hash(maddr);
  assign mrd1 = hash(maddr1);

  memory_port_arbiter #(.MEMORY_LATENCY(LAT), .STARVATION_LIMIT(LIMIT), .ADDRESS_WIDTH(32)) dut (
    .system_clock(clk), .reset(rst_n),
    .fetch_request(fr), .fetch_address(fa), .fetch_ready(fready), .fetch_read_data(fdata),
    .data_request(dr), .data_write(dw), .data_address(da), .data_write_data(dwd),
    .data_ready(dready), .data_read_data(ddata),
    .memory_enable(men), .memory_write(mwr), .memory_address(maddr),
    .memory_write_data(mwd), .memory_read_data(mrd), .busy(busy), .grant_owner(gown));

  memory_port_arbiter #(.MEMORY_LATENCY(1), .STARVATION_LIMIT(LIMIT), .ADDRESS_WIDTH(32)) dut_lat1 (
    .system_clock(clk), .reset(rst_n),
    .fetch_request(fr1), .fetch_address(fa1), .fetch_ready(fready1), .fetch_read_data(fdata1),
    .data_request(zero1), .data_write(zero1), .data_address(zero32), .data_write_data(zero32),
    .data_ready(dready1), .data_read_data(ddata1),
    .memory_enable(men1), .memory_write(mwr1), .memory_address(maddr1),
    .memory_write_data(mwd1), .memory_read_data(mrd1), .busy(busy1), .grant_owner(gown1));

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Transaction model: one outstanding access, timed relative to its grant cycle.
  bit          m_active;
  int          m_start;
  int          m_starve;
  bit          m_owner, m_write;
  logic [31:0] m_addr, m_wdata, m_frd, m_drd;

  task automatic chk1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0; m_start = 0; m_starve = 0; m_owner = 1'b0; m_write = 1'b0;
    m_addr = 32'd0; m_wdata = 32'd0; m_frd = 32'd0; m_drd = 32'd0;
  endtask

  task automatic model_step();
    bit give_data;
    if (!rst_n) return;
    if (m_active && cyc == m_start + LAT && !m_write) begin
      if (m_owner) m_drd = ovr_en ? ovr_val : hash(m_addr);
      else         m_frd = ovr_en ? ovr_val : hash(m_addr);
    end
    if ((!m_active || cyc >= m_start + LAT + 2) && (fr || dr)) begin
      give_data = dr && !(fr && m_starve == LIMIT);
      m_owner   = give_data;
      if (give_data) begin
        m_addr = da; m_write = dw; m_wdata = dwd;
        m_starve = fr ? m_starve + 1 : 0;
      end else begin
        m_addr = fa; m_write = 1'b0; m_wdata = 32'd0;
        m_starve = 0;
      end
      m_active = 1'b1;
      m_start  = cyc;
    end
  endtask

  task automatic compare_all();
    int  ph;
    bit  acc, done;
    ph   = cyc - m_start;
    acc  = m_active && ph >= 1 && ph <= LAT;
    done = m_active && ph == LAT + 1;
    chk1("busy", busy, acc || done);
    chk1("memory_enable", men, acc);
    chk1("memory_write", mwr, acc && m_write);
    if (acc) chk32("memory_address", maddr, m_addr);
    if (acc && m_write) chk32("memory_write_data", mwd, m_wdata);
    chk1("fetch_ready", fready, done && !m_owner);
    chk1("data_ready", dready, done && m_owner);
    chk1("ready_exclusive", fready & dready, 1'b0);
    chk32("fetch_read_data", fdata, m_frd);
    chk32("data_read_data", ddata, m_drd);
    chk1("grant_owner", gown, m_owner);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    cyc++;
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    chk1("reset_enable", men, 1'b0);
    chk1("reset_busy", busy, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    bit          f_seen, d_seen;
    logic [31:0] saved;
    rst_n = 1'b0; fr = 0; dr = 0; dw = 0; fa = 0; da = 0; dwd = 0;
    ovr_en = 1'b0; ovr_val = 32'd0; fr1 = 0; fa1 = 0; zero1 = 0; zero32 = 0;
    model_reset();
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Single fetch with a known instruction word.
    ovr_en = 1'b1; ovr_val = 32'h8C080004; fr = 1'b1; fa = 32'h10;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk1("t1_enable", men, k <= 2);
      chk1("t1_ready", fready, k == 3);
      chk1("t1_busy", busy, k <= 3);
      if (k <= 2) chk32("t1_address", maddr, 32'h10);
      if (k == 3) begin
        chk32("t1_data", fdata, 32'h8C080004);
        chk32("t1_model_data", m_frd, 32'h8C080004);
      end
      if (k == 4) fr = 1'b0;
    end
    ovr_en = 1'b0;

    // Simultaneous requests: data first, fetch second.
    dr = 1'b1; dw = 1'b0; da = 32'h200; fr = 1'b1; fa = 32'h4;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 1) begin chk1("t2_owner_data", gown, 1'b1); chk32("t2_addr_data", maddr, 32'h200); end
      chk1("t2_dready", dready, k == 3);
      chk1("t2_fready", fready, k == 7);
      if (k == 3) chk32("t2_ddata", ddata, hash(32'h200));
      if (k == 4) dr = 1'b0;
      if (k == 5) begin chk1("t2_owner_fetch", gown, 1'b0); chk32("t2_addr_fetch", maddr, 32'h4); end
      if (k == 7) chk32("t2_fdata", fdata, hash(32'h4));
      if (k == 8) fr = 1'b0;
    end

    // Data write leaves the load register alone.
    dr = 1'b1; dw = 1'b1; da = 32'h100; dwd = 32'hDEADBEEF;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk1("t3_write", mwr, k <= 2);
      chk1("t3_enable", men, k <= 2);
      if (k <= 2) chk32("t3_wdata", mwd, 32'hDEADBEEF);
      chk1("t3_dready", dready, k == 3);
      if (k == 3) chk32("t3_ddata_kept", ddata, hash(32'h200));
      if (k == 4) begin dr = 1'b0; dw = 1'b0; end
    end

    // Starvation guard: fetch forced after LIMIT contested data grants.
    fr = 1'b1; fa = 32'h300; dr = 1'b1; dw = 1'b0; da = 32'h400;
    for (int n = 0; n < 6; n++) begin
      tick();
      chk1("t4_owner", gown, (n == 4) ? 1'b0 : 1'b1);
      tick(); tick(); tick();
      fa = fa + 32'd4; da = da + 32'd4;
    end
    fr = 1'b0; dr = 1'b0;
    tick();

    // Reset mid-access, fetch still requesting afterwards.
    fr = 1'b1; fa = 32'h40;
    tick(); tick();
    do_reset();
    for (int k = 1; k <= LAT + 2; k++) begin
      tick();
      chk1("t5_ready", fready, k == LAT + 1);
      if (k == LAT + 1) chk32("t5_data", fdata, hash(32'h40));
      if (k == LAT + 2) fr = 1'b0;
    end

    // Randomized requesters.
    f_seen = 1'b0; d_seen = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (f_seen) begin
        f_seen = 1'b0;
        if ($urandom_range(1, 0) == 0) fr = 1'b0; else fa = $urandom;
      end else if (!fr && $urandom_range(3, 0) == 0) begin
        fr = 1'b1; fa = $urandom;
      end
      if (d_seen) begin
        d_seen = 1'b0;
        if ($urandom_range(3, 0) == 0) dr = 1'b0;
        else begin da = $urandom; dw = $urandom_range(1, 0) == 1; dwd = $urandom; end
      end else if (!dr && $urandom_range(3, 0) != 0) begin
        dr = 1'b1; da = $urandom; dw = $urandom_range(1, 0) == 1; dwd = $urandom;
      end
      if (fready) f_seen = 1'b1;
      if (dready) d_seen = 1'b1;
    end
    fr = 1'b0; dr = 1'b0;

    // Single-cycle latency instance with fetch held continuously.
    saved = 32'h1000;
    fr1 = 1'b1; fa1 = saved;
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk1("lat1_enable", men1, (k % 3) == 1);
      chk1("lat1_ready", fready1, (k % 3) == 2);
      if ((k % 3) == 2) chk32("lat1_data", fdata1, hash(32'h1000 + 32'(4 * ((k - 2) / 3))));
      if ((k % 3) == 0) fa1 = 32'h1000 + 32'(4 * (k / 3));
    end
    fr1 = 1'b0;
    tick(); tick(); tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
